// File: rtl/bist_march_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bist_march_ctrl
//
// Purpose: sequences a March C- memory test over a 2^A_WIDTH-word memory,
// steering an external up/down address generator and checking read data.
//   M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 down r0,w1 | M4 down r1,w0 |
//   M5 up r0          (0 = all-zeros word, 1 = all-ones word)
//
// Optional build macro: BIST_FAIL_LOG_EN adds first-mismatch log outputs.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       begin a run (honoured in IDLE or DONE only)
//   ag_carry    one-cycle pulse: generator has reached its terminal address
//   ag_address  current generator address
//   ag_reset    load generator with 0          (INIT of up elements)
//   ag_preset   load generator with all-ones   (INIT of down elements)
//   ag_en       step generator
//   ag_up_down  step direction, 1 = up
//   mem_we      memory write strobe
//   mem_re      memory read strobe (data returns on mem_rdata next cycle)
//   mem_wdata   write data
//   mem_rdata   read data
//   busy        run in progress (INIT/OP0/OP1/DRAIN)
//   done        run complete (DONE state)
//   fail        sticky mismatch flag, cleared by start or reset
//   elem        index of the current March element
//   fail_addr / fail_elem / fail_data  (BIST_FAIL_LOG_EN only)
//               address, element and read data of the first mismatch
// ---------------------------------------------------------------------------
module bist_march_ctrl #(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ag_carry,
  input  logic [A_WIDTH-1:0] ag_address,
  output logic               ag_reset,
  output logic               ag_preset,
  output logic               ag_en,
  output logic               ag_up_down,
  output logic               mem_we,
  output logic               mem_re,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [2:0]         elem
`ifdef BIST_FAIL_LOG_EN
  ,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [2:0]         fail_elem,
  output logic [D_WIDTH-1:0] fail_data
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_OP0   = 3'd2;
  localparam logic [2:0] S_OP1   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int N_ELEMS = 6;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [2:0]         r_elem;
  logic [2:0]         w_elem_next;
  logic               r_last;
  logic               r_fail;
  logic               r_cmp_pend;
  logic [D_WIDTH-1:0] r_cmp_exp;

  logic [N_ELEMS-1:0] w_elem_hit;
  logic               w_dir_up;
  logic               w_two_op;
  logic               w_op0_write;
  logic               w_op0_ones;
  logic               w_op1_ones;
  logic               w_last_elem;
  logic               w_in_init;
  logic               w_in_op0;
  logic               w_in_op1;
  logic               w_terminal;
  logic               w_final_op;
  logic               w_start_ok;
  logic               w_mismatch;

  // One-hot element decode; codes 6 and 7 are never reached.
  genvar gi;
  generate
    for (gi = 0; gi < N_ELEMS; gi++) begin : g_elem_dec
      assign w_elem_hit[gi] = (r_elem == 3'(gi));
    end
  endgenerate

  // Element table. OP0 of M1..M5 is a read; its data pattern doubles as the
  // expected read value. OP1 (M1..M4 only) writes the complement.
  assign w_dir_up    = ~(w_elem_hit[3] | w_elem_hit[4]);
  assign w_two_op    = |w_elem_hit[4:1];
  assign w_op0_write = w_elem_hit[0];
  assign w_op0_ones  = w_elem_hit[2] | w_elem_hit[4];
  assign w_op1_ones  = w_elem_hit[1] | w_elem_hit[3];
  assign w_last_elem = w_elem_hit[5];

  assign w_in_init  = (r_state == S_INIT);
  assign w_in_op0   = (r_state == S_OP0);
  assign w_in_op1   = (r_state == S_OP1);
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // The carry pulse lines up with OP0 of the terminal address; r_last holds
  // it so that OP1 of a two-op element still knows it is at the end.
  assign w_terminal = ag_carry | r_last;
  assign w_final_op = (w_in_op0 & ~w_two_op) | w_in_op1;

  // -------------------------------------------------------------------------
  // State machine
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_elem_next  = r_elem;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_INIT;
          w_elem_next  = 3'd0;
        end
      end
      S_INIT: begin
        w_state_next = S_OP0;
      end
      S_OP0: begin
        if (w_two_op) begin
          w_state_next = S_OP1;
        end else if (w_terminal) begin
          if (w_last_elem) begin
            w_state_next = S_DRAIN;
          end else begin
            w_state_next = S_INIT;
            w_elem_next  = r_elem + 3'd1;
          end
        end
      end
      S_OP1: begin
        if (w_terminal) begin
          w_state_next = S_INIT;
          w_elem_next  = r_elem + 3'd1;
        end else begin
          w_state_next = S_OP0;
        end
      end
      S_DRAIN: begin
        // Lets the final M5 read be compared before done rises.
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_elem  <= 3'd0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_elem  <= w_elem_next;
      if (w_in_init) begin
        r_last <= 1'b0;
      end else if ((w_in_op0 | w_in_op1) & ag_carry) begin
        r_last <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read compare: expected word registered alongside the read strobe, data
  // checked the following cycle. Reset drops any compare still in flight.
  // -------------------------------------------------------------------------
  assign w_mismatch = r_cmp_pend & (mem_rdata != r_cmp_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmp_pend <= 1'b0;
      r_cmp_exp  <= '0;
      r_fail     <= 1'b0;
    end else begin
      r_cmp_pend <= mem_re;
      r_cmp_exp  <= {D_WIDTH{w_op0_ones}};
      if (w_start_ok) begin
        r_fail <= 1'b0;
      end else if (w_mismatch) begin
        r_fail <= 1'b1;
      end
    end
  end

`ifdef BIST_FAIL_LOG_EN
  // First-mismatch log. r_fail doubles as the "already logged" flag, so
  // later mismatches leave the captured values alone.
  logic [A_WIDTH-1:0] r_cmp_addr;
  logic [2:0]         r_cmp_elem;
  logic [A_WIDTH-1:0] r_fail_addr;
  logic [2:0]         r_fail_elem;
  logic [D_WIDTH-1:0] r_fail_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmp_addr  <= '0;
      r_cmp_elem  <= 3'd0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_fail_data <= '0;
    end else begin
      r_cmp_addr <= ag_address;
      r_cmp_elem <= r_elem;
      if (w_start_ok) begin
        r_fail_addr <= '0;
        r_fail_elem <= 3'd0;
        r_fail_data <= '0;
      end else if (w_mismatch & ~r_fail) begin
        r_fail_addr <= r_cmp_addr;
        r_fail_elem <= r_cmp_elem;
        r_fail_data <= mem_rdata;
      end
    end
  end

  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
  assign fail_data = r_fail_data;
`else
  // Without the log the address is only consumed by the generator itself.
  logic w_unused_addr;
  assign w_unused_addr = ^ag_address;
`endif

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state, so reset forces them quiet)
  // -------------------------------------------------------------------------
  assign ag_reset   = w_in_init & w_dir_up;
  assign ag_preset  = w_in_init & ~w_dir_up;
  assign ag_en      = w_final_op & ~w_terminal;
  assign ag_up_down = w_dir_up;

  assign mem_we = (w_in_op0 & w_op0_write) | w_in_op1;
  assign mem_re = w_in_op0 & ~w_op0_write;

  always_comb begin
    mem_wdata = '0;
    if (w_in_op0 & w_op0_write) begin
      mem_wdata = {D_WIDTH{w_op0_ones}};
    end else if (w_in_op1) begin
      mem_wdata = {D_WIDTH{w_op1_ones}};
    end
  end

  assign busy = w_in_init | w_in_op0 | w_in_op1 | (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);
  assign fail = r_fail;
  assign elem = r_elem;

endmodule

// File: tb/tb_bist_march_ctrl.sv
`timescale 1ns/1ps
// Testbench for bist_march_ctrl: behavioural address generator and memory
// with fault injection, a March C- reference built from the element table,
// and a scoreboard that checks every memory operation as it appears.
module tb_bist_march_ctrl;
  localparam int AW         = 4;
  localparam int DW         = 8;
  localparam int N          = 1 << AW;
  localparam int RUN_CYCLES = 10 * N + 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ag_carry;
  logic [AW-1:0] ag_address;
  logic          ag_reset, ag_preset, ag_en, ag_up_down;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, fail;
  logic [2:0]    elem;
`ifdef BIST_FAIL_LOG_EN
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
`endif

  always #5 clk = ~clk;

  bist_march_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ag_carry(ag_carry), .ag_address(ag_address),
    .ag_reset(ag_reset), .ag_preset(ag_preset), .ag_en(ag_en), .ag_up_down(ag_up_down),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail), .elem(elem)
`ifdef BIST_FAIL_LOG_EN
    , .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data)
`endif
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [2:0]    elem;
    logic          up;
    logic          en;
  } op_t;

  op_t  sb_ops[$];   // expected memory operations, in order
  logic sb_init[$];  // expected INIT direction per element
  op_t  run_ops[$];  // reference op list of the current run
  int   run_ridx[$]; // read ordinal of each op (-1 for writes)

  int checks   = 0;
  int failures = 0;

  // fault configuration
  int            st0_addr = -1;
  logic [DW-1:0] st0_mask = '0;
  int            st1_addr = -1;
  logic [DW-1:0] st1_mask = '0;
  int            flip_idx0 = -1;
  int            flip_idx1 = -1;
  logic [DW-1:0] flip_mask = 8'h01;
  logic          cnt_clr = 1'b0;

  // reference results
  logic          exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [2:0]    exp_felem;
  logic [DW-1:0] exp_fdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fault_write(input int a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (a == st0_addr) r = r & ~st0_mask;
    if (a == st1_addr) r = r | st1_mask;
    return r;
  endfunction

  // ---------------- address generator model ----------------
  always @(posedge clk) begin
    logic [AW-1:0] nxt;
    ag_carry <= 1'b0;
    if (reset) begin
      ag_address <= '0;
    end else if (ag_reset) begin
      ag_address <= '0;
    end else if (ag_preset) begin
      ag_address <= '1;
    end else if (ag_en) begin
      nxt = ag_up_down ? ag_address + 1'b1 : ag_address - 1'b1;
      ag_address <= nxt;
      ag_carry   <= ag_up_down ? (nxt == AW'(N - 1)) : (nxt == '0);
    end
  end

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [N];
  int            rd_cnt = 0;
  always @(posedge clk) begin
    logic [DW-1:0] rdv;
    if (cnt_clr) rd_cnt <= 0;
    if (mem_we) mem[ag_address] <= fault_write(int'(ag_address), mem_wdata);
    if (mem_re) begin
      rdv = mem[ag_address];
      // a read issued during reset returns corrupted data: its compare must be dropped
      if (rd_cnt == flip_idx0 || rd_cnt == flip_idx1 || reset) rdv = rdv ^ flip_mask;
      mem_rdata <= rdv;
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic void build_ops();
    int  ridx;
    op_t o;
    ridx = 0;
    run_ops.delete();
    run_ridx.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        logic          up;
        logic          term;
        logic [DW-1:0] rd;
        up     = !(e == 3 || e == 4);
        term   = (i == N - 1);
        o.addr = up ? AW'(i) : AW'(N - 1 - i);
        o.elem = 3'(e);
        o.up   = up;
        rd     = (e == 2 || e == 4) ? '1 : '0;
        if (e == 0 || e == 5) begin
          o.we = (e == 0);
          o.d  = '0;
          o.en = !term;
          run_ops.push_back(o);
          run_ridx.push_back(o.we ? -1 : ridx);
          if (!o.we) ridx++;
        end else begin
          o.we = 1'b0; o.d = rd;  o.en = 1'b0;
          run_ops.push_back(o);
          run_ridx.push_back(ridx);
          ridx++;
          o.we = 1'b1; o.d = ~rd; o.en = !term;
          run_ops.push_back(o);
          run_ridx.push_back(-1);
        end
      end
    end
  endfunction

  function automatic int read_index(input int e, input int a);
    foreach (run_ops[k])
      if (!run_ops[k].we && run_ops[k].elem == 3'(e) && run_ops[k].addr == AW'(a))
        return run_ridx[k];
    return -1;
  endfunction

  function automatic void eval_model();
    logic [DW-1:0] m [N];
    logic [DW-1:0] got;
    exp_fail  = 1'b0;
    exp_faddr = '0;
    exp_felem = '0;
    exp_fdata = '0;
    foreach (run_ops[k]) begin
      if (run_ops[k].we) begin
        m[run_ops[k].addr] = fault_write(int'(run_ops[k].addr), run_ops[k].d);
      end else begin
        got = m[run_ops[k].addr];
        if (run_ridx[k] == flip_idx0 || run_ridx[k] == flip_idx1) got = got ^ flip_mask;
        if (got != run_ops[k].d && !exp_fail) begin
          exp_fail  = 1'b1;
          exp_faddr = run_ops[k].addr;
          exp_felem = run_ops[k].elem;
          exp_fdata = got;
        end
      end
    end
  endfunction

  task automatic clear_faults();
    st0_addr  = -1; st0_mask = '0;
    st1_addr  = -1; st1_mask = '0;
    flip_idx0 = -1; flip_idx1 = -1;
  endtask

  task automatic queue_run();
    foreach (run_ops[k]) sb_ops.push_back(run_ops[k]);
    for (int e = 0; e < 6; e++) sb_init.push_back(!(e == 3 || e == 4));
  endtask

  task automatic issue_start();
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(posedge clk); #1;
    start   = 1'b1;
    cnt_clr = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    op_t            e;
    logic           up;
    logic [AW+DW+7:0] act_v, exp_v;
    forever begin
      @(negedge clk);
      if (mem_we || mem_re) begin
        if (sb_ops.size() == 0) begin
          check("unexpected_strobe", 64'(1), 64'(0));
        end else begin
          e     = sb_ops.pop_front();
          exp_v = {1'b0, e.we, e.addr, e.d, e.elem, e.up, e.en};
          act_v = {mem_we & mem_re, mem_we, ag_address, (mem_we ? mem_wdata : e.d),
                   elem, ag_up_down, ag_en};
          check("mem_op", 64'(act_v), 64'(exp_v));
        end
      end else if (ag_en) begin
        check("stray_ag_en", 64'(1), 64'(0));
      end
      if (ag_reset || ag_preset) begin
        if (sb_init.size() == 0) begin
          check("unexpected_ag_load", 64'(1), 64'(0));
        end else begin
          up = sb_init.pop_front();
          check("ag_load", 64'({ag_reset, ag_preset}), 64'({up, !up}));
        end
      end
    end
  end

  // ---------------- run tasks ----------------
  task automatic do_run(input string tag, input int midstart);
    int got;
    queue_run();
    issue_start();
    got = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      start   = (k == midstart);
      cnt_clr = 1'b0;
      @(negedge clk);
      if (done) begin
        got = k;
        break;
      end
    end
    start = 1'b0;
    check("run_len", 64'(got), 64'(RUN_CYCLES));
    check("fail_flag", 64'(fail), 64'(exp_fail));
    check("busy_in_done", 64'(busy), 64'(0));
    check("ops_left", 64'(sb_ops.size()), 64'(0));
    check("inits_left", 64'(sb_init.size()), 64'(0));
`ifdef BIST_FAIL_LOG_EN
    check("log", 64'({fail_addr, fail_elem, fail_data}), 64'({exp_faddr, exp_felem, exp_fdata}));
`endif
    sb_ops.delete();
    sb_init.delete();
    $display("run %-12s cycles=%0d fail=%0d exp_fail=%0d first=(elem %0d addr %0d data %0h)",
             tag, got, fail, exp_fail, exp_felem, exp_faddr, exp_fdata);
  endtask

  task automatic prep_and_run(input string tag, input int midstart);
    build_ops();
    eval_model();
    do_run(tag, midstart);
  endtask

  task automatic do_reset_run();
    int r;
    int found;
    clear_faults();
    build_ops();
    eval_model();
    queue_run();
    issue_start();
    @(posedge clk); #1;
    start   = 1'b0;
    cnt_clr = 1'b0;
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (elem == 3'd3 && mem_re) begin
        found = 1;
        break;
      end
    end
    check("reach_m3", 64'(found), 64'(1));
    // land on a later M3 read cycle (OP0) and reset there
    r = $urandom_range(0, 6);
    repeat (2 * r + 2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_ops.delete();
    sb_init.delete();
    @(negedge clk);
    check("post_reset", 64'({busy, done, fail, elem, mem_we, mem_re, ag_en, ag_reset, ag_preset}), 64'(0));
`ifdef BIST_FAIL_LOG_EN
    check("post_reset_log", 64'({fail_addr, fail_elem, fail_data}), 64'(0));
`endif
    repeat (4) @(negedge clk);
    check("dropped_compare", 64'({fail, busy}), 64'(0));
    $display("run %-12s reset in M3 after %0d extra addresses", "reset_m3", r);
  endtask

  // ---------------- main stimulus ----------------
  initial begin : stim
    int kind;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", 64'({busy, done, fail, elem, mem_we, mem_re, mem_wdata, ag_en, ag_reset, ag_preset}), 64'(0));
`ifdef BIST_FAIL_LOG_EN
    check("reset_log", 64'({fail_addr, fail_elem, fail_data}), 64'(0));
`endif

    clear_faults();
    prep_and_run("ideal", 0);
    prep_and_run("start_mid", 50);

    clear_faults();
    st0_addr = 5; st0_mask = 8'h08;
    prep_and_run("stuck0_a5b3", 0);

    clear_faults();
    build_ops();
    flip_mask = 8'(1 << $urandom_range(0, DW - 1));
    flip_idx0 = read_index(1, 2);
    flip_idx1 = read_index(4, 9);
    eval_model();
    do_run("two_flips", 0);

    do_reset_run();
    clear_faults();
    prep_and_run("after_reset", 0);

    for (int i = 0; i < 4; i++) begin
      clear_faults();
      kind = $urandom_range(0, 3);
      build_ops();
      case (kind)
        1: begin st0_addr = $urandom_range(0, N - 1); st0_mask = 8'(1 << $urandom_range(0, DW - 1)); end
        2: begin st1_addr = $urandom_range(0, N - 1); st1_mask = 8'(1 << $urandom_range(0, DW - 1)); end
        3: begin
          flip_mask = 8'(1 << $urandom_range(0, DW - 1));
          flip_idx0 = read_index($urandom_range(1, 5), $urandom_range(0, N - 1));
        end
        default: ;
      endcase
      eval_model();
      do_run($sformatf("random%0d_k%0d", i, kind), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 160) : 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
